mcu_mem_arbiter: RTL and testbench

- Shares the cartridge memory port (ROM/SRAM) between SNES bus accesses and MCU/SD-DMA accesses.
- Latches single-shot MCU read/write requests (mcu_rrq/mcu_wrq, addr_out, mcu_data_out, mcu_write from the command decoder).
- Runs each latched request as a timed memory cycle in a window where the SNES is not accessing memory.
- Returns mcu_rq_rdy and the read byte to the command decoder.

---
 rtl/mcu_mem_pkg.sv | 35 +++
 rtl/mcu_mem_arbiter_if.sv | 37 +++
 rtl/mcu_req_latch.sv | 60 ++++++
 rtl/mcu_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mcu_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_mem_pkg.sv
// Shared types and constants for the MCU memory arbiter.
//   arb_state_e : arbiter FSM states
//   mcu_op_e    : kind of latched MCU access (read, write, no-op DMA write)
//   mcu_req_t   : one latched request (address, write data, op)
//   sat_inc4    : 4-bit saturating increment used by the cycle counters
package mcu_mem_pkg;

    localparam int unsigned ADDR_W       = 24;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned STARVE_LIMIT = 1023;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StRecover
    } arb_state_e;

    typedef enum logic [1:0] {
        OpRead,
        OpWrite,
        OpNop
    } mcu_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        mcu_op_e           op;
    } mcu_req_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/mcu_mem_arbiter_if.sv
// Signal bundle between the arbiter and its surroundings (command decoder side and
// cartridge memory port side).
//   slave  : arbiter view (request/snes_busy/mem_din in; completion and memory strobes out)
//   master : environment view (the mirror image)
interface mcu_mem_arbiter_if;
    import mcu_mem_pkg::*;

    logic              mcu_rrq;
    logic              mcu_wrq;
    logic              mcu_write;
    logic [ADDR_W-1:0] mcu_addr;
    logic [DATA_W-1:0] mcu_wdata;
    logic              mcu_rq_rdy;
    logic [DATA_W-1:0] mcu_rdata;
    logic              snes_busy;
    logic              mem_sel_mcu;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_oe;
    logic              mem_we;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_dout_en;
    logic [DATA_W-1:0] mem_din;
    logic              arb_busy;

    modport slave (
        input  mcu_rrq, mcu_wrq, mcu_write, mcu_addr, mcu_wdata, snes_busy, mem_din,
        output mcu_rq_rdy, mcu_rdata, mem_sel_mcu, mem_addr, mem_oe, mem_we, mem_dout,
               mem_dout_en, arb_busy
    );

    modport master (
        output mcu_rrq, mcu_wrq, mcu_write, mcu_addr, mcu_wdata, snes_busy, mem_din,
        input  mcu_rq_rdy, mcu_rdata, mem_sel_mcu, mem_addr, mem_oe, mem_we, mem_dout,
               mem_dout_en, arb_busy
    );

endinterface

// File: rtl/mcu_req_latch.sv
// One-deep pending slot for MCU request pulses.
//   clk, rst   : clock, async active-high reset
//   rrq_i/wrq_i: single-cycle read/write request pulses (write wins if both)
//   write_i    : 0 = real write; 1 = DMA write without WE, run as a no-op cycle
//   addr_i, wdata_i : request payload
//   clr_i      : request finished, empty the slot (a same-cycle new pulse wins)
//   pending_o, req_o : slot state and contents
// ovf_q is a sticky flag: a pulse arrived while the slot still held an unserved request.
module mcu_req_latch
    import mcu_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rrq_i,
    input  logic              wrq_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              clr_i,
    output logic              pending_o,
    output mcu_req_t          req_o
);

    logic     pending_q, pending_d;
    logic     ovf_q, ovf_d;
    mcu_req_t req_q, req_d;
    logic     set;

    always_comb begin
        set       = rrq_i | wrq_i;
        pending_d = set | (pending_q & ~clr_i);
        ovf_d     = ovf_q | (set & pending_q & ~clr_i);
        req_d     = req_q;
        if (set) begin
            req_d.addr  = addr_i;
            req_d.wdata = wdata_i;
            if (wrq_i) begin
                req_d.op = write_i ? OpNop : OpWrite;
            end else begin
                req_d.op = OpRead;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= 1'b0;
            ovf_q     <= 1'b0;
            req_q     <= '{addr: '0, wdata: '0, op: OpRead};
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            req_q     <= req_d;
        end
    end

    assign pending_o = pending_q;
    assign req_o     = req_q;

endmodule

// File: rtl/mcu_mem_arbiter.sv
// Arbitrates the cartridge memory port between SNES bus cycles and MCU / SD-DMA
// accesses. A latched MCU request runs as SETUP -> STROBE -> RECOVER while the SNES
// is not accessing memory; completion is a one-cycle mcu_rq_rdy pulse.
//   clk, rst : clock, async active-high reset
//   bus      : mcu_mem_arbiter_if.slave (request side, memory side, arb_busy)
// Parameters: ACC_CYCLES (strobe length, 2..15), SETUP_CYCLES (address setup, 1..3).
// Optional: define MCU_STARVE_GUARD_EN to force an access after STARVE_LIMIT clocks of
// continuous SNES activity; without it a request waits for as long as snes_busy is high.
module mcu_mem_arbiter
    import mcu_mem_pkg::*;
#(
    parameter int unsigned ACC_CYCLES   = 4,
    parameter int unsigned SETUP_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    mcu_mem_arbiter_if.slave bus
);

    localparam logic [3:0] SetupLast = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] AccLast   = 4'(ACC_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    mcu_op_e           op_q, op_d;
    logic              rdy_q, rdy_d;

    logic              pending;
    mcu_req_t          req;
    logic              pend_clr;
    logic              grant;
    logic              force_grant;
    logic              forced_q;

    mcu_req_latch u_req_latch (
        .clk       (clk),
        .rst       (rst),
        .rrq_i     (bus.mcu_rrq),
        .wrq_i     (bus.mcu_wrq),
        .write_i   (bus.mcu_write),
        .addr_i    (bus.mcu_addr),
        .wdata_i   (bus.mcu_wdata),
        .clr_i     (pend_clr),
        .pending_o (pending),
        .req_o     (req)
    );

`ifdef MCU_STARVE_GUARD_EN
    logic [9:0] wait_q, wait_d;
    logic       forced_d;
    logic       starved_q, starved_d;

    assign force_grant = (wait_q == 10'(STARVE_LIMIT));

    always_comb begin
        wait_d    = wait_q;
        forced_d  = forced_q;
        starved_d = starved_q;
        if (grant) begin
            wait_d = '0;
            // Only a grant that actually overrode snes_busy counts as forced.
            forced_d  = force_grant & bus.snes_busy;
            starved_d = starved_q | (force_grant & bus.snes_busy);
        end else if (state_q == StIdle && pending && bus.snes_busy && !force_grant) begin
            wait_d = wait_q + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q    <= '0;
            forced_q  <= 1'b0;
            starved_q <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            forced_q  <= forced_d;
            starved_q <= starved_d;
        end
    end
`else
    assign force_grant = 1'b0;
    assign forced_q    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        dout_d   = dout_q;
        rdata_d  = rdata_q;
        op_d     = op_q;
        rdy_d    = 1'b0;
        pend_clr = 1'b0;
        grant    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending && (!bus.snes_busy || force_grant)) begin
                    // Payload copied so a later overwrite of the slot cannot disturb
                    // the access in flight.
                    grant   = 1'b1;
                    state_d = StSetup;
                    cnt_d   = '0;
                    addr_d  = req.addr;
                    dout_d  = req.wdata;
                    op_d    = req.op;
                end
            end
            StSetup: begin
                if (bus.snes_busy && !forced_q) begin
                    // Back off; the request stays pending and is retried from IDLE.
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q >= SetupLast) begin
                    state_d = StStrobe;
                    cnt_d   = '0;
                end else begin
                    cnt_d = sat_inc4(cnt_q);
                end
            end
            StStrobe: begin
                if (cnt_q >= AccLast) begin
                    state_d = StRecover;
                    cnt_d   = '0;
                    if (op_q == OpRead) begin
                        rdata_d = bus.mem_din;
                    end
                end else begin
                    cnt_d = sat_inc4(cnt_q);
                end
            end
            StRecover: begin
                state_d  = StIdle;
                rdy_d    = 1'b1;
                pend_clr = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            op_q    <= OpRead;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            rdy_q   <= rdy_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them immediately.
    assign bus.mem_sel_mcu = (state_q != StIdle);
    assign bus.mem_addr    = addr_q;
    assign bus.mem_oe      = (state_q == StStrobe) && (op_q == OpRead);
    assign bus.mem_we      = (state_q == StStrobe) && (op_q == OpWrite);
    assign bus.mem_dout    = dout_q;
    assign bus.mem_dout_en = (state_q != StIdle) && (op_q == OpWrite);
    assign bus.mcu_rq_rdy  = rdy_q;
    assign bus.mcu_rdata   = rdata_q;
    assign bus.arb_busy    = pending | (state_q != StIdle);

endmodule

// File: tb/tb_mcu_mem_arbiter.sv
// Directed bench for mcu_mem_arbiter with default parameters (SETUP 1, ACC 4).
module tb_mcu_mem_arbiter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    mcu_mem_arbiter_if bus ();

    mcu_mem_arbiter #(
        .ACC_CYCLES   (4),
        .SETUP_CYCLES (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mcu_rrq = 0; bus.mcu_wrq = 0; bus.mcu_write = 0;
        bus.mcu_addr = '0; bus.mcu_wdata = '0; bus.snes_busy = 0; bus.mem_din = '0;
        #12;
        n_vec++;
        if ({bus.mem_sel_mcu, bus.mem_oe, bus.mem_we, bus.mem_dout_en, bus.mcu_rq_rdy,
             bus.arb_busy} !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ctl got %b%b%b%b%b%b required 000000", bus.mem_sel_mcu,
                     bus.mem_oe, bus.mem_we, bus.mem_dout_en, bus.mcu_rq_rdy, bus.arb_busy);
        end
        n_vec++;
        if (bus.mem_addr !== 24'h0 || bus.mcu_rdata !== 8'h0 || bus.mem_dout !== 8'h0) begin
            n_err++;
            $display("FAIL reset_data got addr %h rdata %h dout %h required 0",
                     bus.mem_addr, bus.mcu_rdata, bus.mem_dout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Read at idle bus: addr at t0+1, oe t0+2..t0+5, rdy t0+7.
    task automatic test_read(input logic [23:0] a, input logic [7:0] d);
        logic exp;
        bus.mcu_addr = a; bus.mem_din = d; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
        n_vec++;
        if (bus.arb_busy !== 1'b1) begin
            n_err++; $display("FAIL read_busy got %b required 1", bus.arb_busy);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            exp = (k >= 2 && k <= 5);
            n_vec++;
            if (bus.mem_oe !== exp || bus.mem_we !== 1'b0) begin
                n_err++;
                $display("FAIL read_strobe k=%0d got oe %b we %b required oe %b we 0",
                         k, bus.mem_oe, bus.mem_we, exp);
            end
            exp = (k == 7);
            n_vec++;
            if (bus.mcu_rq_rdy !== exp) begin
                n_err++;
                $display("FAIL read_rdy k=%0d got %b required %b", k, bus.mcu_rq_rdy, exp);
            end
            if (k == 1) begin
                n_vec++;
                if (bus.mem_addr !== a || bus.mem_sel_mcu !== 1'b1) begin
                    n_err++;
                    $display("FAIL read_addr got %h sel %b required %h sel 1",
                             bus.mem_addr, bus.mem_sel_mcu, a);
                end
            end
        end
        n_vec++;
        if (bus.mcu_rdata !== d || bus.arb_busy !== 1'b0) begin
            n_err++;
            $display("FAIL read_data got %h busy %b required %h busy 0",
                     bus.mcu_rdata, bus.arb_busy, d);
        end
    endtask

    // Write (write_n=0) or DMA no-op (write_n=1).
    task automatic test_write(input logic write_n, input logic [7:0] prev_rdata);
        logic exp;
        int   rdy_cnt;
        rdy_cnt = 0;
        bus.mcu_addr = 24'h000010; bus.mcu_wdata = 8'hC3; bus.mcu_write = write_n;
        bus.mcu_wrq = 1;
        step();
        bus.mcu_wrq = 0; bus.mcu_write = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
            exp = !write_n && (k >= 2 && k <= 5);
            n_vec++;
            if (bus.mem_we !== exp || bus.mem_oe !== 1'b0) begin
                n_err++;
                $display("FAIL write_we wn=%b k=%0d got we %b oe %b required we %b oe 0",
                         write_n, k, bus.mem_we, bus.mem_oe, exp);
            end
            exp = !write_n && (k >= 1 && k <= 6);
            n_vec++;
            if (bus.mem_dout_en !== exp) begin
                n_err++;
                $display("FAIL write_douten wn=%b k=%0d got %b required %b",
                         write_n, k, bus.mem_dout_en, exp);
            end
            if (k == 3) begin
                n_vec++;
                if (bus.mem_dout !== 8'hC3 || bus.mem_addr !== 24'h000010) begin
                    n_err++;
                    $display("FAIL write_bus got dout %h addr %h required c3 000010",
                             bus.mem_dout, bus.mem_addr);
                end
            end
        end
        n_vec++;
        if (rdy_cnt != 1 || bus.mcu_rdata !== prev_rdata) begin
            n_err++;
            $display("FAIL write_rdy wn=%b got %0d pulses rdata %h required 1 pulse rdata %h",
                     write_n, rdy_cnt, bus.mcu_rdata, prev_rdata);
        end
    endtask

    task automatic test_contention();
        int rdy_cnt;
        int bad;
        bad = 0;
        rdy_cnt = 0;
        bus.snes_busy = 1; bus.mcu_addr = 24'h00F00D; bus.mem_din = 8'h11; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.mem_oe !== 1'b0 || bus.mem_sel_mcu !== 1'b0 || bus.arb_busy !== 1'b1)
                bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++; $display("FAIL contend_hold got %0d bad cycles required 0", bad);
        end
        bus.snes_busy = 0;
        step();
        n_vec++;
        if (bus.mem_oe !== 1'b0 || bus.mem_sel_mcu !== 1'b1) begin
            n_err++;
            $display("FAIL contend_setup got oe %b sel %b required oe 0 sel 1",
                     bus.mem_oe, bus.mem_sel_mcu);
        end
        step();
        n_vec++;
        if (bus.mem_oe !== 1'b1) begin
            n_err++; $display("FAIL contend_strobe got %b required 1", bus.mem_oe);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt != 1 || bus.mcu_rdata !== 8'h11) begin
            n_err++;
            $display("FAIL contend_done got %0d pulses rdata %h required 1 pulse rdata 11",
                     rdy_cnt, bus.mcu_rdata);
        end
    endtask

    task automatic test_setup_abort();
        int rdy_cnt;
        rdy_cnt = 0;
        bus.mcu_addr = 24'h0A0B0C; bus.mem_din = 8'h3C; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
        step();
        bus.snes_busy = 1;
        step();
        n_vec++;
        if (bus.mem_sel_mcu !== 1'b0 || bus.mem_oe !== 1'b0 || bus.arb_busy !== 1'b1) begin
            n_err++;
            $display("FAIL abort_idle got sel %b oe %b busy %b required 0 0 1",
                     bus.mem_sel_mcu, bus.mem_oe, bus.arb_busy);
        end
        bus.snes_busy = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt != 1 || bus.mcu_rdata !== 8'h3C) begin
            n_err++;
            $display("FAIL abort_retry got %0d pulses rdata %h required 1 pulse rdata 3c",
                     rdy_cnt, bus.mcu_rdata);
        end
    endtask

    task automatic test_back_to_back();
        int rdy_cnt;
        rdy_cnt = 0;
        bus.mcu_addr = 24'h111111; bus.mem_din = 8'h21; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
        repeat (6) step();
        // RECOVER cycle of the first access
        bus.mcu_addr = 24'h222222; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
        n_vec++;
        if (bus.mcu_rq_rdy !== 1'b1 || bus.arb_busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first got rdy %b busy %b required 1 1",
                     bus.mcu_rq_rdy, bus.arb_busy);
        end
        step();
        n_vec++;
        if (bus.mem_addr !== 24'h222222 || bus.mem_sel_mcu !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second got addr %h sel %b required 222222 sel 1",
                     bus.mem_addr, bus.mem_sel_mcu);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt != 1 || dut.u_req_latch.ovf_q !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done got %0d pulses ovf %b required 1 pulse ovf 0",
                     rdy_cnt, dut.u_req_latch.ovf_q);
        end
    endtask

    task automatic test_overflow();
        int rdy_cnt;
        rdy_cnt = 0;
        bus.snes_busy = 1;
        bus.mcu_addr = 24'h333333; bus.mcu_rrq = 1;
        step();
        bus.mcu_addr = 24'h444444;
        step();
        bus.mcu_rrq = 0;
        n_vec++;
        if (dut.u_req_latch.ovf_q !== 1'b1) begin
            n_err++; $display("FAIL ovf_flag got %b required 1", dut.u_req_latch.ovf_q);
        end
        bus.snes_busy = 0;
        step();
        n_vec++;
        if (bus.mem_addr !== 24'h444444) begin
            n_err++; $display("FAIL ovf_addr got %h required 444444", bus.mem_addr);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt != 1) begin
            n_err++; $display("FAIL ovf_rdy got %0d pulses required 1", rdy_cnt);
        end
    endtask

    task automatic test_async_reset();
        bus.mcu_addr = 24'h0000E0; bus.mcu_wdata = 8'h99; bus.mcu_write = 0; bus.mcu_wrq = 1;
        step();
        bus.mcu_wrq = 0;
        repeat (3) step();
        n_vec++;
        if (bus.mem_we !== 1'b1) begin
            n_err++; $display("FAIL arst_pre got we %b required 1", bus.mem_we);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.mem_we, bus.mem_oe, bus.mem_sel_mcu, bus.mem_dout_en, bus.arb_busy} !== 5'b0)
        begin
            n_err++;
            $display("FAIL arst_drop got we%b oe%b sel%b den%b busy%b required all 0",
                     bus.mem_we, bus.mem_oe, bus.mem_sel_mcu, bus.mem_dout_en, bus.arb_busy);
        end
        step();
        n_vec++;
        if (bus.mcu_rq_rdy !== 1'b0) begin
            n_err++; $display("FAIL arst_rdy got %b required 0", bus.mcu_rq_rdy);
        end
        rst = 1'b0;
        step();
        test_read(24'h00ABCD, 8'hA7);
    endtask

    task automatic test_starve();
        int n;
        int rdy_cnt;
        logic seen;
        rdy_cnt = 0;
        seen = 0;
        n = 0;
        bus.snes_busy = 1; bus.mcu_addr = 24'h555555; bus.mem_din = 8'h77; bus.mcu_rrq = 1;
        step();
        bus.mcu_rrq = 0;
`ifdef MCU_STARVE_GUARD_EN
        while (n < 1100 && !seen) begin
            step();
            n++;
            if (bus.mem_sel_mcu === 1'b1) seen = 1;
        end
        n_vec++;
        if (!seen || n != 1024) begin
            n_err++;
            $display("FAIL starve_force got seen %b after %0d clk required seen 1 after 1024",
                     seen, n);
        end
        step();
        n_vec++;
        if (bus.mem_oe !== 1'b1 || dut.starved_q !== 1'b1) begin
            n_err++;
            $display("FAIL starve_strobe got oe %b starved %b required 1 1",
                     bus.mem_oe, dut.starved_q);
        end
`else
        for (int k = 0; k < 5000; k++) begin
            step();
            if (bus.mem_sel_mcu !== 1'b0 || bus.mem_oe !== 1'b0) seen = 1;
        end
        n_vec++;
        if (seen || bus.arb_busy !== 1'b1) begin
            n_err++;
            $display("FAIL starve_wait got access %b busy %b required access 0 busy 1",
                     seen, bus.arb_busy);
        end
        bus.snes_busy = 0;
`endif
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus.mcu_rq_rdy === 1'b1) rdy_cnt++;
        end
        n_vec++;
        if (rdy_cnt != 1 || bus.mcu_rdata !== 8'h77) begin
            n_err++;
            $display("FAIL starve_done got %0d pulses rdata %h required 1 pulse rdata 77",
                     rdy_cnt, bus.mcu_rdata);
        end
        bus.snes_busy = 0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_read(24'h123456, 8'h5A);
        test_write(1'b0, 8'h5A);
        test_write(1'b1, 8'h5A);
        test_contention();
        test_setup_abort();
        test_back_to_back();
        test_overflow();
        test_async_reset();
        test_starve();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
